// File: rtl/phy_reset_sequencer_if.sv
// Control/status bundle for the PHY reset sequencer: release gates, soft-reset
// requests, delay configuration, scan bypass and the sequenced reset outputs.
interface phy_reset_sequencer_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int CNT_WIDTH    = 8
);
  logic                    upstream_reset_in_n;
  logic [NUM_CHANNELS-1:0] soft_reset_req_in;
  logic [CNT_WIDTH-1:0]    delay_cfg_in;
  logic                    scan_mode_en_in;
  logic                    scan_reset_in_n;
  logic [NUM_CHANNELS-1:0] reset_out_n;
  logic                    seq_busy_out;
  logic                    seq_done_out;

  modport master (
    output upstream_reset_in_n, soft_reset_req_in, delay_cfg_in,
           scan_mode_en_in, scan_reset_in_n,
    input  reset_out_n, seq_busy_out, seq_done_out
  );

  modport slave (
    input  upstream_reset_in_n, soft_reset_req_in, delay_cfg_in,
           scan_mode_en_in, scan_reset_in_n,
    output reset_out_n, seq_busy_out, seq_done_out
  );
endinterface

// File: rtl/phy_reset_sequencer.sv
// Releases NUM_CHANNELS active-low PHY resets in index order after a minimum hold,
// gated by the upstream reset, with per-channel soft re-entry and a scan bypass.
// Latency: channel i releases M+2+d+i*(d+1) edges after reset; no backpressure.
module phy_reset_sequencer #(
  parameter int NUM_CHANNELS = 4,
  parameter int CNT_WIDTH    = 8,
  parameter int MIN_ASSERT   = 4
) (
  input  logic                   sync_clock_in,
  input  logic                   reset_in,
  phy_reset_sequencer_if.slave   seq_if
);
  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int HOLD_W = (MIN_ASSERT > 1) ? $clog2(MIN_ASSERT) : 1;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT_UP,
    ST_DELAY,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0] rst_q, rst_d;
  logic                    soft_found;
  logic [IDX_W-1:0]        soft_k;

  always_ff @(posedge sync_clock_in) begin
    if (reset_in) begin
      state_q <= ST_ASSERT;
      idx_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      rst_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    rst_d      = rst_q;
    soft_found = 1'b0;
    soft_k     = '0;

    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (seq_if.soft_reset_req_in[i] && !soft_found) begin
        soft_found = 1'b1;
        soft_k     = IDX_W'(i);
      end
    end

    if (!seq_if.upstream_reset_in_n && (state_q == ST_DELAY || state_q == ST_DONE)) begin
      state_d = ST_ASSERT;
      idx_d   = '0;
      hold_d  = '0;
      rst_d   = '0;
    end else if (soft_found) begin
      // Re-assert the requested channel and everything above it; lower ones stay up.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (IDX_W'(i) >= soft_k) rst_d[i] = 1'b0;
      end
      if (soft_k < idx_q) idx_d = soft_k;
      state_d = ST_ASSERT;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (hold_q == HOLD_W'(MIN_ASSERT - 1)) state_d = ST_WAIT_UP;
          else                                   hold_d  = hold_q + HOLD_W'(1);
        end
        ST_WAIT_UP: begin
          if (seq_if.upstream_reset_in_n) begin
            cnt_d   = seq_if.delay_cfg_in;
            state_d = ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
          end else begin
            rst_d[idx_q] = 1'b1;
            if (idx_q == IDX_W'(NUM_CHANNELS - 1)) begin
              state_d = ST_DONE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = seq_if.delay_cfg_in;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Scan bypass sits after the registers so the sequence keeps running underneath.
  assign seq_if.reset_out_n  = seq_if.scan_mode_en_in ? {NUM_CHANNELS{seq_if.scan_reset_in_n}}
                                                      : rst_q;
  assign seq_if.seq_done_out = (state_q == ST_DONE);
  assign seq_if.seq_busy_out = (state_q != ST_DONE);
endmodule
